// File: rtl/button_pulse_array.sv
// Per-channel 2-FF sync, debounce and edge/auto-repeat pulse generator for raw board inputs.
// Latency: capture at edge k -> level at k+DB_CYCLES+1, pulse at k+DB_CYCLES+2; no backpressure, masked pulses are dropped.
module button_pulse_array #(
  parameter int WIDTH         = 4,
  parameter int DB_CYCLES     = 16,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
  input  logic             en,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse,
  output logic             any_pulse
);

  localparam int DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RMAX + 1);
  localparam bit USE_REP = (REPEAT_EN != 0) && (EDGE_MODE == 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("button_pulse_array: EDGE_MODE must be 0, 1 or 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic           s1, s2, lvl, lvl_d, pls;
    logic [DBW-1:0] cnt;
    logic [RW-1:0]  rcnt;
    logic [RW-1:0]  rcnt_inc;
    rep_state_t     st;
    logic           rise, fall, edge_hit, db_accept, db_fall, rep_fire;

    assign rise      = lvl & ~lvl_d;
    assign fall      = ~lvl & lvl_d;
    assign db_accept = (s2 != lvl) && (cnt == DBW'(DB_CYCLES - 1));
    // Debouncer is about to drop the level this edge; repeat must not fire on it.
    assign db_fall   = db_accept & lvl;
    assign rcnt_inc  = rcnt + 1'b1;

    always_comb begin
      case (EDGE_MODE)
        1:       edge_hit = fall;
        2:       edge_hit = rise | fall;
        default: edge_hit = rise;
      endcase
    end

    always_comb begin
      rep_fire = 1'b0;
      if (USE_REP && lvl && !db_fall) begin
        case (st)
          DELAY:   rep_fire = (rcnt_inc == RW'(REPEAT_DELAY));
          REPEAT:  rep_fire = (rcnt_inc == RW'(REPEAT_PERIOD));
          default: rep_fire = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        cnt   <= '0;
        pls   <= 1'b0;
        st    <= IDLE;
        rcnt  <= '0;
      end else begin
        s1    <= in_raw[i];
        s2    <= s1;
        lvl_d <= lvl;

        if (s2 == lvl) begin
          cnt <= '0;
        end else if (db_accept) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end

        pls <= en & (edge_hit | rep_fire);

        // Repeat counters run regardless of en so the cadence survives masking.
        if (!USE_REP || !lvl || db_fall) begin
          st   <= IDLE;
          rcnt <= '0;
        end else begin
          case (st)
            IDLE: begin
              if (rise) begin
                st   <= DELAY;
                rcnt <= '0;
              end
            end
            DELAY: begin
              if (rep_fire) begin
                st   <= REPEAT;
                rcnt <= '0;
              end else begin
                rcnt <= rcnt_inc;
              end
            end
            REPEAT: begin
              if (rep_fire) rcnt <= '0;
              else          rcnt <= rcnt_inc;
            end
            default: begin
              st   <= IDLE;
              rcnt <= '0;
            end
          endcase
        end
      end
    end

    assign level[i] = lvl;
    assign pulse[i] = pls;
  end

  assign any_pulse = |pulse;

endmodule
